display_reader: RTL
===================

DISPLAY_READER -- requirements
Module: display_reader

Interface
REQ-001 SHALL have parameter ESTABLE, default 4: consecutive identical cycles required to accept a digit.
REQ-002 SHALL have parameter TIMEOUT, default 65535: cycles without an accepted digit before loss-of-signal.
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port anodos, input, 4: digit select, active-low; bit i selects digit i, with digit 0 rightmost.
REQ-006 SHALL have port catodos, input, 8: segments {a,b,c,d,e,f,g,dp}, active-low; dp (bit 0) is ignored.
REQ-007 SHALL have port digitos, output, 16: four 4-bit codes, with digit i at [4i+3:4i].
REQ-008 SHALL have port temp_leida, output, 7: decimal value 10*digit1 + digit0.
REQ-009 SHALL have port frame_listo, output, 1: one-cycle pulse when digitos and temp_leida update.
REQ-010 SHALL have port error_seg, output, 1: sticky until the next frame; last frame contained an illegal pattern.
REQ-011 SHALL have port sin_senal, output, 1: level; no digit accepted for TIMEOUT cycles.

Function
REQ-012 SHALL treat anodos as valid only when exactly one bit is 0; any other value is idle and clears the stability counter.
REQ-013 SHALL use a three-state FSM: ESPERA, ESTABILIZANDO and CAPTURADO.
REQ-014 SHALL move ESPERA->ESTABILIZANDO on a valid anodos and load the counter with 1.
REQ-015 SHALL, in ESTABILIZANDO, increment the counter while {anodos,catodos[7:1]} equals the previous cycle's value.
REQ-016 SHALL, in ESTABILIZANDO, restart the counter at 1 on any change to a different valid anodos, and go to ESPERA on an invalid anodos.
REQ-017 SHALL, when the counter reaches ESTABLE, decode catodos[7:1] into the shadow register for the selected digit, set that digit's seen bit, and go to CAPTURADO.
REQ-018 SHALL stay in CAPTURADO until {anodos,catodos[7:1]} changes, then proceed exactly as from ESPERA in that same cycle, so the same digit is not captured twice.
REQ-019 SHALL decode digits 0-9 with the standard seven-segment table (for example '0'=1111110 on, '1'=0110000 on).
REQ-020 SHALL decode all segments off (blank) to code 4'hF.
REQ-021 SHALL decode any other pattern to code 4'hE and set the frame error bit.
REQ-022 SHALL, in the cycle after all four seen bits are set, copy the shadow registers to digitos, compute temp_leida, and pulse frame_listo for exactly 1 cycle.
REQ-023 SHALL, in that same cycle, set error_seg to the frame error bit and clear the seen bits and the frame error bit.
REQ-024 SHALL compute temp_leida as 0 whenever digit0 or digit1 is not 0-9 (a code of E or F), with blank tens counted as 0 only when the units digit is valid.
REQ-025 SHALL, on a recapture of an already-seen digit within a frame, overwrite its shadow register without a frame pulse.
REQ-026 SHALL reset the timeout counter on every accepted digit, set sin_senal on reaching TIMEOUT, and saturate the counter.
REQ-027 SHALL clear sin_senal on the next accepted digit.
REQ-028 SHALL keep digitos and temp_leida unchanged between frames.
REQ-029 SHALL, in a simultaneous event where the frame completes in the same cycle as a new acceptance, perform the frame copy first and record the new digit as seen in the new frame.

Reset
REQ-030 SHALL, on reset, asynchronously force: FSM=ESPERA, counters=0, seen=0000, digitos=16'hFFFF, temp_leida=0, frame_listo=0, error_seg=0, sin_senal=0.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame, and emit no frame_listo until four new digits are accepted after release.

Structure
REQ-032 SHALL place the segment decode table, the codes BLANK=4'hF and ILEGAL=4'hE, and the FSM state encoding in shared package display_pkg.
REQ-033 SHALL implement the decode in sub-module seg_a_bcd (7-bit segments in, 4-bit code and illegal flag out), combinational and instantiated once.

Verification
REQ-034 SHALL verify: scan "0028", each digit held 8 cycles for 2 rounds -> first frame_listo after the 4th digit, digitos=16'h0028, temp_leida=28, error_seg=0.
REQ-035 SHALL verify: digit held only 3 cycles with ESTABLE=4 -> not captured, and no frame_listo.
REQ-036 SHALL verify: digit 2 shows pattern 1111111 on -> digit2 code 8 (legal); digit 2 shows 1000001 on -> code E, error_seg=1 at frame, then 0 after a clean frame.
REQ-037 SHALL verify: anodos=4'b1100 or 4'b1111 for 10 cycles -> no capture, and the counter is cleared.
REQ-038 SHALL verify: stop scanning for TIMEOUT cycles -> sin_senal=1; resume -> sin_senal=0 on the first accepted digit.
REQ-039 SHALL verify: reset after 2 of 4 digits -> outputs at reset values, and the next frame_listo only after 4 fresh digits.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display reader: digit codes, segment table,
// FSM encoding and the two-digit temperature helper.
package display_pkg;

    localparam logic [3:0] BLANK  = 4'hF;
    localparam logic [3:0] ILEGAL = 4'hE;

    typedef enum logic [1:0] {
        StEspera,
        StEstabilizando,
        StCapturado
    } estado_t;

    // Lit segments {a,b,c,d,e,f,g} for digits 9 (first entry) down to 0 (last entry).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
        7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    // Blank tens count as zero, but only when the units digit is a real number.
    function automatic logic [6:0] calc_temp(logic [3:0] d1, logic [3:0] d0);
        if (d0 > 4'd9) return 7'd0;
        if (d1 == BLANK) return {3'b000, d0};
        if (d1 > 4'd9) return 7'd0;
        return 7'(d1) * 7'd10 + 7'(d0);
    endfunction

endpackage

// File: rtl/seg_a_bcd.sv
// Combinational decoder from lit segments {a..g} to a digit code, blank or illegal.
module seg_a_bcd
    import display_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = ILEGAL;
        illegal_o = 1'b1;
        if (seg_i == 7'd0) begin
            code_o    = BLANK;
            illegal_o = 1'b0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (seg_i == SEG_TABLE[i]) begin
                    code_o    = 4'(i);
                    illegal_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/display_reader.sv
// Reads a multiplexed 4-digit seven-segment display back into digit codes, assembling
// complete frames, flagging illegal patterns and detecting loss of scan activity.
module display_reader
    import display_pkg::*;
#(
    parameter int unsigned ESTABLE = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anodos,
    input  logic [7:0]  catodos,
    output logic [15:0] digitos,
    output logic [6:0]  temp_leida,
    output logic        frame_listo,
    output logic        error_seg,
    output logic        sin_senal
);

    localparam int unsigned CntW = $clog2(ESTABLE + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    estado_t         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [10:0]     muestra, prev_q;
    logic            valid, go, capture;
    logic [1:0]      sel;
    logic [6:0]      seg_on;
    logic [3:0]      code;
    logic            illegal;
    logic [3:0]      seen_q;
    logic            err_q;
    logic [3:0][3:0] shadow_q;
    logic [ToW-1:0]  to_q;
    logic [15:0]     digitos_q;
    logic [6:0]      temp_q;
    logic            frame_q, error_q, sin_q;
    logic            unused_dp;

    assign muestra   = {anodos, catodos[7:1]};
    assign seg_on    = ~catodos[7:1];
    assign unused_dp = catodos[0];

    always_comb begin
        valid = 1'b1;
        sel   = 2'd0;
        case (anodos)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: valid = 1'b0;
        endcase
    end

    seg_a_bcd u_dec (
        .seg_i    (seg_on),
        .code_o   (code),
        .illegal_o(illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go      = 1'b0;
        capture = 1'b0;
        case (state_q)
            StEspera: go = valid;
            StEstabilizando: begin
                if (!valid) begin
                    state_d = StEspera;
                end else if (muestra == prev_q) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    go = 1'b1;
                end
            end
            StCapturado: begin
                if (muestra != prev_q) begin
                    go = valid;
                    if (!valid) state_d = StEspera;
                end
            end
            default: state_d = StEspera;
        endcase
        if (!valid) cnt_d = '0;
        if (go) begin
            state_d = StEstabilizando;
            cnt_d   = CntW'(1);
        end
        if (state_d == StEstabilizando && cnt_d == CntW'(ESTABLE)) begin
            capture = 1'b1;
            state_d = StCapturado;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StEspera;
            cnt_q     <= '0;
            prev_q    <= '0;
            seen_q    <= 4'b0000;
            err_q     <= 1'b0;
            shadow_q  <= {4{BLANK}};
            to_q      <= '0;
            digitos_q <= 16'hFFFF;
            temp_q    <= 7'd0;
            frame_q   <= 1'b0;
            error_q   <= 1'b0;
            sin_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= muestra;
            if (capture) shadow_q[sel] <= code;
            // Frame copy reads the old shadows; a same-cycle capture opens the next frame.
            if (seen_q == 4'hF) begin
                digitos_q <= shadow_q;
                temp_q    <= calc_temp(shadow_q[1], shadow_q[0]);
                error_q   <= err_q;
                frame_q   <= 1'b1;
                seen_q    <= capture ? (4'b0001 << sel) : 4'b0000;
                err_q     <= capture & illegal;
            end else begin
                frame_q <= 1'b0;
                if (capture) begin
                    seen_q[sel] <= 1'b1;
                    err_q       <= err_q | illegal;
                end
            end
            if (capture) begin
                to_q  <= '0;
                sin_q <= 1'b0;
            end else if (to_q != ToW'(TIMEOUT)) begin
                to_q <= to_q + ToW'(1);
                if (to_q == ToW'(TIMEOUT - 1)) sin_q <= 1'b1;
            end
        end
    end

    assign digitos     = digitos_q;
    assign temp_leida  = temp_q;
    assign frame_listo = frame_q;
    assign error_seg   = error_q;
    assign sin_senal   = sin_q;

endmodule
